// File: rtl/dcache_ctrl.sv
// Data-cache controller: runs MEM-stage loads and stores through the dcache
// and a byte-serial RAM port. Stores are write-through with write-allocate.
// I/O addresses bypass the cache.
module dcache_ctrl #(
  parameter logic [1:0] IO_SEL = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        sext_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        busy_o,
  output logic [31:0] dc_raddr_o,
  output logic [1:0]  dc_rbyte_o,
  input  logic        dc_hit_i,
  input  logic [31:0] dc_data_i,
  output logic        dc_we_o,
  output logic [1:0]  dc_wbyte_o,
  output logic [31:0] dc_waddr_o,
  output logic [31:0] dc_wdata_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic [31:0] mem_a_o,
  output logic        mem_wr_o,
  output logic [7:0]  mem_dout_o,
  input  logic [7:0]  mem_din_i
);

  typedef enum logic [2:0] {StIdle, StLookup, StRd, StWr, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d;
  logic        sext_q, sext_d;
  logic [31:0] wdata_q, wdata_d;
  logic        cach_q, cach_d;
  logic        miss_q, miss_d;
  logic [2:0]  issue_q, issue_d;
  logic [2:0]  recv_q, recv_d;
  logic        pend_q, pend_d;   // a granted read byte arrives this cycle
  logic [31:0] data_q, data_d;   // raw assembled bytes
  logic [31:0] rdata_q, rdata_d;

  logic [2:0]  nbytes;
  logic [31:0] lane_mask;
  logic [31:0] asm_data;
  logic        issue_more;

  // Zero- or sign-extend the low byte/half of a raw little-endian word.
  function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] sz,
                                         input logic sx);
    case (sz)
      2'b00:   return {{24{sx & d[7]}}, d[7:0]};
      2'b01:   return {{16{sx & d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  // Transfer length and byte mask from the latched (normalised) size.
  always_comb begin
    case (size_q)
      2'b00:   begin nbytes = 3'd1; lane_mask = 32'h0000_00ff; end
      2'b01:   begin nbytes = 3'd2; lane_mask = 32'h0000_ffff; end
      default: begin nbytes = 3'd4; lane_mask = 32'hffff_ffff; end
    endcase
    issue_more = (issue_q < nbytes);
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    we_d     = we_q;
    sext_d   = sext_q;
    wdata_d  = wdata_q;
    cach_d   = cach_q;
    miss_d   = miss_q;
    issue_d  = issue_q;
    recv_d   = recv_q;
    pend_d   = pend_q;
    data_d   = data_q;
    rdata_d  = rdata_q;
    asm_data = data_q;
    asm_data[{recv_q[1:0], 3'b000} +: 8] = mem_din_i;

    case (state_q)
      StIdle: begin
        if (req_i) begin
          addr_d  = addr_i;
          size_d  = (size_i == 2'b11) ? 2'b10 : size_i;
          we_d    = we_i;
          sext_d  = sext_i;
          wdata_d = wdata_i;
          cach_d  = (addr_i[17:16] != IO_SEL);
          miss_d  = 1'b0;
          issue_d = 3'd0;
          recv_d  = 3'd0;
          pend_d  = 1'b0;
          data_d  = 32'h0;
          if (we_i)                           state_d = StWr;
          else if (addr_i[17:16] != IO_SEL)   state_d = StLookup;
          else                                state_d = StRd;
        end
      end
      StLookup: begin
        if (dc_hit_i) begin
          data_d  = dc_data_i;
          rdata_d = extend(dc_data_i, size_q, sext_q);
          state_d = StDone;
        end else begin
          miss_d  = 1'b1;
          issue_d = 3'd0;
          recv_d  = 3'd0;
          pend_d  = 1'b0;
          data_d  = 32'h0;
          state_d = StRd;
        end
      end
      StRd: begin
        pend_d = mem_gnt_i && issue_more;
        if (mem_gnt_i && issue_more) issue_d = issue_q + 3'd1;
        if (pend_q) begin
          data_d = asm_data;
          recv_d = recv_q + 3'd1;
          if (recv_q + 3'd1 == nbytes) begin
            rdata_d = extend(asm_data, size_q, sext_q);
            state_d = StDone;
          end
        end
      end
      StWr: begin
        if (mem_gnt_i) begin
          issue_d = issue_q + 3'd1;
          if (issue_q == nbytes - 3'd1) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register; rdy low freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= 32'h0;
      size_q  <= 2'b00;
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      wdata_q <= 32'h0;
      cach_q  <= 1'b0;
      miss_q  <= 1'b0;
      issue_q <= 3'd0;
      recv_q  <= 3'd0;
      pend_q  <= 1'b0;
      data_q  <= 32'h0;
      rdata_q <= 32'h0;
    end else if (rdy) begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      we_q    <= we_d;
      sext_q  <= sext_d;
      wdata_q <= wdata_d;
      cach_q  <= cach_d;
      miss_q  <= miss_d;
      issue_q <= issue_d;
      recv_q  <= recv_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    done_o     = 1'b0;
    rdata_o    = rdata_q;
    busy_o     = (state_q != StIdle);
    dc_raddr_o = 32'h0;
    dc_rbyte_o = 2'b00;
    dc_we_o    = 1'b0;
    dc_wbyte_o = 2'b00;
    dc_waddr_o = 32'h0;
    dc_wdata_o = 32'h0;
    mem_req_o  = 1'b0;
    mem_a_o    = 32'h0;
    mem_wr_o   = 1'b0;
    mem_dout_o = 8'h0;
    if (state_q != StIdle) begin
      dc_raddr_o = addr_q;
      dc_rbyte_o = size_q;
    end
    case (state_q)
      StRd: begin
        if (issue_more) begin
          mem_req_o = 1'b1;
          mem_a_o   = addr_q + {29'h0, issue_q};
        end
      end
      StWr: begin
        mem_req_o  = 1'b1;
        mem_wr_o   = 1'b1;
        mem_a_o    = addr_q + {29'h0, issue_q};
        mem_dout_o = wdata_q[{issue_q[1:0], 3'b000} +: 8];
      end
      StDone: begin
        done_o = 1'b1;
        if (cach_q && (we_q || miss_q)) begin
          dc_we_o    = 1'b1;
          dc_wbyte_o = size_q;
          dc_waddr_o = addr_q;
          dc_wdata_o = we_q ? (wdata_q & lane_mask) : data_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios followed by random
// transactions, checked against a transaction-level model of the controller.
module tb_dcache_ctrl;
  localparam logic [1:0] IO_SEL = 2'b11;

  logic        clk = 1'b0;
  logic        rst, rdy, req_i, we_i, sext_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i, wdata_i;
  logic        done_o, busy_o, dc_we_o, mem_req_o, mem_wr_o;
  logic [31:0] rdata_o, dc_raddr_o, dc_waddr_o, dc_wdata_o, mem_a_o;
  logic [1:0]  dc_rbyte_o, dc_wbyte_o;
  logic        dc_hit_i, mem_gnt_i;
  logic [31:0] dc_data_i;
  logic [7:0]  mem_dout_o, mem_din_i;

  always #5 clk = ~clk;

  dcache_ctrl #(.IO_SEL(IO_SEL)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .req_i(req_i), .we_i(we_i), .size_i(size_i),
    .sext_i(sext_i), .addr_i(addr_i), .wdata_i(wdata_i), .done_o(done_o),
    .rdata_o(rdata_o), .busy_o(busy_o), .dc_raddr_o(dc_raddr_o), .dc_rbyte_o(dc_rbyte_o),
    .dc_hit_i(dc_hit_i), .dc_data_i(dc_data_i), .dc_we_o(dc_we_o), .dc_wbyte_o(dc_wbyte_o),
    .dc_waddr_o(dc_waddr_o), .dc_wdata_o(dc_wdata_o), .mem_req_o(mem_req_o),
    .mem_gnt_i(mem_gnt_i), .mem_a_o(mem_a_o), .mem_wr_o(mem_wr_o),
    .mem_dout_o(mem_dout_o), .mem_din_i(mem_din_i)
  );

  // RAM contents: a fixed hash of the address, with per-address overrides.
  logic [7:0] mem_ov [logic [31:0]];
  function automatic logic [7:0] ram(input logic [31:0] a);
    if (mem_ov.exists(a)) return mem_ov[a];
    return (a[7:0] * 8'd7) ^ a[15:8] ^ a[31:24] ^ 8'h3c;
  endfunction

  // RAM read port: byte appears the cycle after a granted read address.
  always @(posedge clk)
    if (!rst && rdy && mem_req_o && mem_gnt_i && !mem_wr_o) mem_din_i <= ram(mem_a_o);

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Observations from the most recent transaction.
  logic [31:0] obs_rd[$];
  logic [31:0] obs_wa[$];
  logic [7:0]  obs_wb[$];
  int          obs_lat, obs_addr_err, obs_freeze_err;
  logic        obs_timeout, obs_dcwe;
  logic [31:0] obs_rdata, obs_waddr, obs_wdata;
  logic [1:0]  obs_wbyte, obs_after;
  logic [31:0] model_rdata = 32'h0;   // rdata_o as the model predicts it

  function automatic logic grant(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 2) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic run_txn(input logic we, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd, input logic hit,
                         input logic [31:0] hd, input int gmode, input int stall_at);
    int cyc;
    logic [31:0] issued, snap_a;
    logic [7:0]  snap_d;
    logic        snap_req;
    obs_rd.delete(); obs_wa.delete(); obs_wb.delete();
    obs_addr_err = 0; obs_freeze_err = 0; obs_timeout = 1'b0; obs_lat = 0;
    snap_a = 32'h0; snap_d = 8'h0; snap_req = 1'b0;
    @(negedge clk);
    we_i = we; size_i = sz; sext_i = sx; addr_i = a; wdata_i = wd;
    dc_hit_i = hit; dc_data_i = hd; req_i = 1'b1; rdy = 1'b1;
    cyc = 0; issued = 32'h0;
    mem_gnt_i = grant(gmode, cyc);
    while (1) begin
      @(negedge clk);
      cyc++;
      if (done_o) begin
        obs_lat = cyc; obs_rdata = rdata_o; obs_dcwe = dc_we_o;
        obs_waddr = dc_waddr_o; obs_wbyte = dc_wbyte_o; obs_wdata = dc_wdata_o;
        break;
      end
      if (cyc > 200) begin obs_timeout = 1'b1; break; end
      if (stall_at >= 0 && cyc == stall_at) begin
        snap_a = mem_a_o; snap_d = mem_dout_o; snap_req = mem_req_o;
      end
      if (stall_at >= 0 && cyc > stall_at && cyc <= stall_at + 3)
        if (mem_a_o !== snap_a || mem_dout_o !== snap_d || mem_req_o !== snap_req)
          obs_freeze_err++;
      rdy = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 3);
      if (mem_req_o && mem_a_o !== a + issued) obs_addr_err++;
      mem_gnt_i = grant(gmode, cyc);
      if (rdy && mem_req_o && mem_gnt_i) begin
        if (mem_wr_o) begin obs_wa.push_back(mem_a_o); obs_wb.push_back(mem_dout_o); end
        else obs_rd.push_back(mem_a_o);
        issued++;
      end
    end
    req_i = 1'b0; mem_gnt_i = 1'b0; rdy = 1'b1;
    @(negedge clk);
    obs_after = {done_o, busy_o};
  endtask

  // Compare the last transaction against the transaction-level model.
  task automatic check_txn(input logic we, input logic [1:0] sz, input logic sx,
                           input logic [31:0] a, input logic [31:0] wd, input logic hit,
                           input logic [31:0] hd, input int gmode, input logic stalled);
    int unsigned n;
    logic        cach, exp_we;
    logic [31:0] raw, mask, val;
    longint      full;
    n    = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    cach = (a[17:16] != IO_SEL);
    mask = (n == 4) ? 32'hffff_ffff : 32'((64'd1 << (8 * n)) - 1);
    chk("timeout", 32'(obs_timeout), 32'h0);
    chk("addr_seq", 32'(obs_addr_err), 32'h0);
    chk("freeze", 32'(obs_freeze_err), 32'h0);
    chk("done_pulse", 32'(obs_after), 32'h0);
    raw = 32'h0;
    if (we) begin
      chk("wr_count", 32'(obs_wa.size()), 32'(n));
      chk("rd_count", 32'(obs_rd.size()), 32'h0);
      for (int i = 0; i < int'(n) && i < obs_wa.size(); i++) begin
        chk("wr_addr", obs_wa[i], a + 32'(i));
        chk("wr_byte", 32'(obs_wb[i]), 32'((wd >> (8 * i)) & 32'hff));
      end
    end else begin
      chk("wr_count", 32'(obs_wa.size()), 32'h0);
      if (cach && hit) begin
        raw = hd;
        chk("rd_count", 32'(obs_rd.size()), 32'h0);
      end else begin
        for (int i = 0; i < int'(n); i++) raw = raw | (32'(ram(a + 32'(i))) << (8 * i));
        chk("rd_count", 32'(obs_rd.size()), 32'(n));
        for (int i = 0; i < int'(n) && i < obs_rd.size(); i++)
          chk("rd_addr", obs_rd[i], a + 32'(i));
      end
      val  = raw & mask;
      full = longint'(val);
      if (sx && n < 4 && full >= (longint'(1) << (8 * n - 1))) full = full - (longint'(1) << (8 * n));
      model_rdata = 32'(full);
    end
    chk("rdata", obs_rdata, model_rdata);
    exp_we = cach && (we || !hit);
    chk("dc_we", 32'(obs_dcwe), 32'(exp_we));
    if (exp_we) begin
      chk("dc_waddr", obs_waddr, a);
      chk("dc_wbyte", 32'(obs_wbyte), (sz == 2'b11) ? 32'd2 : 32'(sz));
      chk("dc_wdata", obs_wdata, we ? (wd & mask) : (raw & mask));
    end
    if (gmode == 0 && !stalled)
      chk("latency", 32'(obs_lat),
          we ? 32'(n + 1) : (!cach ? 32'(n + 2) : (hit ? 32'd2 : 32'(n + 3))));
  endtask

  logic        r_we, r_sx, r_hit;
  logic [1:0]  r_sz;
  logic [31:0] r_a, r_wd, r_hd;
  int          r_g, we_seen;

  initial begin
    rst = 1'b1; rdy = 1'b1; req_i = 1'b0; we_i = 1'b0; size_i = 2'b00; sext_i = 1'b0;
    addr_i = 32'h0; wdata_i = 32'h0; dc_hit_i = 1'b0; dc_data_i = 32'h0; mem_gnt_i = 1'b0;
    mem_ov[32'h201]   = 8'h80;
    mem_ov[32'h30004] = 8'h34;
    mem_ov[32'h30005] = 8'h92;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy_o), 32'h0);
    chk("reset_rdata", rdata_o, 32'h0);
    chk("reset_memreq", 32'(mem_req_o), 32'h0);
    rst = 1'b0;

    // Store word, continuous grant.
    run_txn(1'b1, 2'b10, 1'b0, 32'h100, 32'h11223344, 1'b0, 32'h0, 0, -1);
    check_txn(1'b1, 2'b10, 1'b0, 32'h100, 32'h11223344, 1'b0, 32'h0, 0, 1'b0);
    // Word load hit.
    run_txn(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 1'b1, 32'h8000ffff, 0, -1);
    check_txn(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 1'b1, 32'h8000ffff, 0, 1'b0);
    chk("hit_rdata_abs", obs_rdata, 32'h8000ffff);
    // Signed byte miss.
    run_txn(1'b0, 2'b00, 1'b1, 32'h201, 32'h0, 1'b0, 32'h0, 0, -1);
    check_txn(1'b0, 2'b00, 1'b1, 32'h201, 32'h0, 1'b0, 32'h0, 0, 1'b0);
    chk("sbyte_rdata_abs", obs_rdata, 32'hffffff80);
    chk("sbyte_fill_abs", obs_wdata, 32'h00000080);
    // Uncached unsigned half, hit asserted but must be ignored.
    run_txn(1'b0, 2'b01, 1'b0, 32'h30004, 32'h0, 1'b1, 32'hdeadbeef, 0, -1);
    check_txn(1'b0, 2'b01, 1'b0, 32'h30004, 32'h0, 1'b1, 32'hdeadbeef, 0, 1'b0);
    chk("io_half_abs", obs_rdata, 32'h00009234);
    // Wrapping word miss with toggling grant.
    run_txn(1'b0, 2'b10, 1'b0, 32'hfffffffe, 32'h0, 1'b0, 32'h0, 1, -1);
    check_txn(1'b0, 2'b10, 1'b0, 32'hfffffffe, 32'h0, 1'b0, 32'h0, 1, 1'b0);
    // rdy low for 3 cycles in the middle of a store word.
    run_txn(1'b1, 2'b10, 1'b0, 32'h440, 32'hcafef00d, 1'b0, 32'h0, 0, 2);
    check_txn(1'b1, 2'b10, 1'b0, 32'h440, 32'hcafef00d, 1'b0, 32'h0, 0, 1'b1);

    // Reset in the middle of an uncached word read.
    @(negedge clk);
    we_i = 1'b0; size_i = 2'b10; sext_i = 1'b0; addr_i = 32'h30010; req_i = 1'b1;
    mem_gnt_i = 1'b1; we_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (dc_we_o) we_seen++;
    end
    chk("pre_rst_busy", 32'(busy_o), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_memreq", 32'(mem_req_o), 32'h0);
    chk("rst_mem_a", mem_a_o, 32'h0);
    chk("rst_dc_raddr", dc_raddr_o, 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_other", 32'({done_o, dc_we_o, mem_wr_o, dc_rbyte_o, dc_wbyte_o} | {mem_dout_o}
                          | dc_waddr_o | dc_wdata_o), 32'h0);
    req_i = 1'b0; mem_gnt_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (dc_we_o) we_seen++;
    end
    chk("rst_no_fill", 32'(we_seen), 32'h0);
    chk("rst_idle", 32'(busy_o), 32'h0);
    model_rdata = 32'h0;

    // Random transactions.
    for (int t = 0; t < 30; t++) begin
      r_we = 1'($urandom_range(0, 2) == 0);
      r_sz = 2'($urandom_range(0, 3));
      r_sx = 1'($urandom_range(0, 1));
      r_a  = $urandom;
      if ($urandom_range(0, 3) == 0) r_a[17:16] = IO_SEL;
      else if (r_a[17:16] == IO_SEL) r_a[16] = 1'b0;
      r_wd  = $urandom;
      r_hit = 1'($urandom_range(0, 1));
      r_hd  = $urandom;
      r_g   = $urandom_range(0, 2);
      run_txn(r_we, r_sz, r_sx, r_a, r_wd, r_hit, r_hd, r_g, -1);
      check_txn(r_we, r_sz, r_sx, r_a, r_wd, r_hit, r_hd, r_g, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
